// File: rtl/mux153_rr_sched_pkg.sv
// mux153_rr_sched_pkg
//   Shared definitions for the SN74XX153 round-robin scheduler: FSM state
//   codes (2'd3 is unused and recovers to IDLE), the strobe-off level and a
//   one-hot helper.
package mux153_rr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  // '153 strobe is active low: 1 forces the mux output to 00.
  localparam logic STR_OFF = 1'b1;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux153_rr_sched_rr_pick4.sv
// rr_pick4
//   Combinational 4-way round-robin picker. Scans req starting at ptr and
//   wrapping modulo 4; returns the first set index.
//   Ports:
//     req    in  [3:0]  request vector
//     ptr    in  [1:0]  highest-priority index this round
//     winner out [1:0]  first set bit at or after ptr (00 when none)
//     any    out        req != 0
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  always_comb begin
    logic [1:0] idx;
    idx    = 2'd0;
    winner = 2'd0;
    any    = |req;
    // Walk from the farthest offset back to ptr so the nearest hit wins.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/mux153_rr_sched.sv
// mux153_rr_sched
//   Shares one SN74XX153 dual 4:1 mux between four requesters (requester k
//   owns mux input k). sel is only changed while the strobe is off, and a
//   SETUP cycle separates the select change from enabling the output.
//   Ports:
//     clk        in        rising-edge clock
//     rst        in        synchronous active-high reset
//     req        in  [3:0] level requests
//     mux_out    in  [1:0] '153 output
//     sel        out [1:0] mux select (registered)
//     str        out       mux strobe (registered, 1 = output forced 00)
//     gnt        out [3:0] one-hot grant (registered)
//     dout       out [1:0] registered sample of mux_out
//     dout_valid out       dout came from the granted input this cycle
//     busy       out       FSM not in IDLE
module mux153_rr_sched
  import mux153_rr_sched_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] mux_out,
  output logic [1:0] sel,
  output logic       str,
  output logic [3:0] gnt,
  output logic [1:0] dout,
  output logic       dout_valid,
  output logic       busy
);

  // HOLD=0 behaves as HOLD=1.
  localparam int            HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_EFF - 1);

  state_t        r_state;
  logic [1:0]    r_sel;
  logic          r_str;
  logic [3:0]    r_gnt;
  logic [1:0]    r_dout;
  logic          r_dout_valid;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_winner;
  logic          w_any;
  logic          w_req_sel;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_req_sel = req[r_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= 2'd0;
      r_str        <= STR_OFF;
      r_gnt        <= 4'd0;
      r_dout       <= 2'd0;
      r_dout_valid <= 1'b0;
      r_ptr        <= 2'd0;
      r_cnt        <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_str <= STR_OFF;
          r_gnt <= 4'd0;
          if (w_any) begin
            r_sel   <= w_winner;
            r_gnt   <= onehot4(w_winner);
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Strobe stays off for this cycle so sel settles first.
          if (w_req_sel) begin
            r_str   <= ~STR_OFF;
            r_cnt   <= CNT_LOAD;
            r_state <= ST_GRANT;
          end else begin
            r_gnt   <= 4'd0;
            r_ptr   <= r_sel + 2'd1;
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_req_sel) begin
            r_dout       <= mux_out;
            r_dout_valid <= 1'b1;
          end
          if (r_cnt == '0 || !w_req_sel) begin
            r_str   <= STR_OFF;
            r_gnt   <= 4'd0;
            r_ptr   <= r_sel + 2'd1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_str   <= STR_OFF;
          r_gnt   <= 4'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel        = r_sel;
  assign str        = r_str;
  assign gnt        = r_gnt;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux153_rr_sched.sv
module tb_mux153_rr_sched;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst1;
  logic [3:0] req, req1;
  logic [1:0] mux_out, sel, dout;
  logic [1:0] mux_out1, sel1, dout1;
  logic       str, dout_valid, busy;
  logic       str1, dv1, busy1;
  logic [3:0] gnt, gnt1;

  // SN74XX153 model, inputs a=11 b=10 c=01 d=00, strobe active low.
  function automatic logic [1:0] ls153(input logic [1:0] s, input logic g_n);
    logic [1:0] v;
    v = 2'b00;
    if (!g_n) begin
      case (s)
        2'd0:    v = 2'b11;
        2'd1:    v = 2'b10;
        2'd2:    v = 2'b01;
        default: v = 2'b00;
      endcase
    end
    return v;
  endfunction

  assign mux_out  = ls153(sel, str);
  assign mux_out1 = ls153(sel1, str1);

  mux153_rr_sched #(.HOLD(HOLD), .CW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .mux_out(mux_out), .sel(sel), .str(str),
    .gnt(gnt), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  mux153_rr_sched #(.HOLD(1), .CW(8)) dut_h1 (
    .clk(clk), .rst(rst1), .req(req1), .mux_out(mux_out1), .sel(sel1), .str(str1),
    .gnt(gnt1), .dout(dout1), .dout_valid(dv1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks who owns the mux and how many cycles since grant.
  // age 0 = setup cycle, age 1..HOLD = enabled cycles.
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_ptr   = 0;
  logic [1:0] m_sel   = 2'd0;
  logic       m_str   = 1'b1;
  logic       m_valid = 1'b0;
  logic [1:0] m_dout  = 2'd0;
  bit         m_init  = 0;
  logic [1:0] sb_q[$];

  always @(posedge clk) begin
    m_valid = 1'b0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_sel = 2'd0; m_str = 1'b1; m_dout = 2'd0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      if (m_owner >= 0) begin
        m_sel = 2'(m_owner);
        m_age = 0;
      end
    end else if (m_age == 0) begin
      if (req[m_owner]) begin
        m_age = 1; m_str = 1'b0;
      end else begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end
    end else begin
      if (req[m_owner]) begin
        m_valid = 1'b1;
        m_dout  = 2'(3 - m_owner);
        sb_q.push_back(m_dout);
      end
      if (!req[m_owner] || m_age == HOLD) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1; m_str = 1'b1;
      end else begin
        m_age++;
      end
    end
    m_init = 1;
  end

  // Monitor: per-cycle output checks plus scoreboard pop on dout_valid.
  logic [1:0] prev_sel = 2'd0;
  always @(negedge clk) begin
    logic [1:0] e;
    if (m_init) begin
      chk("gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
      chk("sel", int'(sel), int'(m_sel));
      chk("str", int'(str), int'(m_str));
      chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
      chk("dout_valid", int'(dout_valid), int'(m_valid));
      chk("dout_hold", int'(dout), int'(m_dout));
      if (sel != prev_sel) chk("str_on_sel_change", int'(str), 1);
      if (dout_valid) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("sb_dout", int'(dout), int'(e));
        end
      end
      prev_sel = sel;
    end
  end

  // HOLD=1 instance: every valid sample is input d (00), spaced 3 cycles.
  int h1_cyc = 0, h1_last = -1, h1_count = 0;
  always @(negedge clk) begin
    h1_cyc++;
    if (dv1) begin
      chk("h1_dout", int'(dout1), 0);
      if (h1_last >= 0) chk("h1_period", h1_cyc - h1_last, 3);
      h1_last = h1_cyc;
      h1_count++;
    end
  end

  initial begin
    rst = 1'b1; req = 4'd0; rst1 = 1'b1; req1 = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_str", int'(str), 1);
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0; rst1 = 1'b0;

    // single requester 1
    req = 4'b0010;
    @(negedge clk);
    chk("e0_gnt", int'(gnt), 2);
    chk("e0_sel", int'(sel), 1);
    @(negedge clk);
    chk("e1_str", int'(str), 0);
    @(negedge clk);
    chk("e2_valid", int'(dout_valid), 1);
    chk("e2_dout", int'(dout), 2);
    repeat (3) @(negedge clk);
    req = 4'd0;
    repeat (3) @(negedge clk);
    chk("idle_after", int'(busy), 0);

    // all requesting: rotation 0,1,2,3
    req = 4'b1111;
    repeat (48) @(negedge clk);
    req = 4'd0;
    repeat (4) @(negedge clk);

    // early drop of requester 2, pointer moves to 3
    req = 4'b0100;
    repeat (4) @(negedge clk);
    req = 4'd0;
    @(negedge clk);
    chk("drop_str", int'(str), 1);
    chk("drop_valid", int'(dout_valid), 0);
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    chk("ptr3_gnt", int'(gnt), 8);
    repeat (8) @(negedge clk);
    req = 4'd0;
    repeat (4) @(negedge clk);

    // one-cycle pulse: SETUP aborts
    req = 4'b0001;
    @(negedge clk);
    req = 4'd0;
    @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    repeat (3) @(negedge clk);

    // reset during GRANT of requester 2
    req = 4'b0100;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_str", int'(str), 1);
    chk("midrst_sel", int'(sel), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    req = 4'd0;
    repeat (4) @(negedge clk);

    // HOLD=1 build, requester 3 held for 30 edges
    req1 = 4'b1000;
    repeat (30) @(negedge clk);
    req1 = 4'd0;
    repeat (4) @(negedge clk);
    chk("h1_count", h1_count, 10);

    // random traffic with rare resets
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 1'b0; req = 4'd0;
    repeat (10) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux153_rr_sched.md
Name: mux153_rr_sched

Overview:
- Round-robin scheduler that shares one SN74XX153 dual 4-to-1 mux between four requesters.
- Requester k owns mux input k: a=0, b=1, c=2, d=3.
- Drives the mux `sel`/`str` with break-before-make sequencing.
- Registers the mux `out` back as `dout`/`dout_valid` for the granted requester.
- Sits beside one SN74XX153 instance in a board-level wrapper; the mux's `out` is wired to `mux_out`.

Parameters:
- HOLD, 4, maximum consecutive GRANT cycles per grant; legal 1..255, 0 treated as 1.
- CW, 8, width of the hold counter; must hold HOLD-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request, bit k for requester k; level, held while service is wanted.
- mux_out  input  2  `out` of the SN74XX153.
- sel  output  2  mux select, registered.
- str  output  1  mux strobe, registered; 1 forces mux `out` to 00, 0 passes the selected input.
- gnt  output  4  one-hot grant, registered; equals 1<<sel while a grant is active, else 0.
- dout  output  2  registered sample of mux_out.
- dout_valid  output  1  dout holds data from the granted input.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, sel=00, str=1, gnt=0000, dout=00, dout_valid=0, ptr=0, cnt=0.
  - rst overrides all other inputs.
  - Mid-grant reset: str returns to 1 at that same edge.
- States: IDLE, SETUP, GRANT.
- IDLE:
  - str=1, gnt=0.
  - If req!=0, winner = first set bit scanning ptr, ptr+1, ... (mod 4).
  - Next edge: sel=winner, gnt=1<<winner, state=SETUP.
  - If req==0, remain IDLE; sel keeps its last value.
- SETUP (exactly 1 cycle; sel settles while strobe is off):
  - If req[sel]=1: str<=0, cnt<=HOLD-1, state<=GRANT.
  - If req[sel]=0 (abort): gnt<=0, ptr<=sel+1, state<=IDLE; str stays 1.
- GRANT (str=0):
  - Each edge with req[sel]=1: dout<=mux_out, dout_valid<=1.
  - Exit when cnt==0 or req[sel]==0, evaluated on pre-edge values.
    - On exit: str<=1, gnt<=0, ptr<=sel+1 (wraps 3->0), state<=IDLE.
    - If exit is due to cnt==0 with req still high, that last cycle's sample is still captured with dout_valid=1.
    - If exit is due to req[sel]==0: dout_valid<=0, dout holds.
  - Otherwise cnt<=cnt-1.
- dout_valid is 0 at every edge not in GRANT. dout holds its last value when not valid.
- Latency: req rises before edge E0 (state IDLE):
  - E0: gnt/sel valid.
  - E1: str=0.
  - E2: first dout_valid=1.
  - Max HOLD valid samples per grant.
- Gap: minimum 2 cycles with str=1 between consecutive grants (IDLE + SETUP). The mux output is never enabled while sel changes.
- Fairness: with req=1111 continuous, grant order is 0,1,2,3,0,...
  - Each grant lasts HOLD GRANT cycles.
  - Period is 4*(HOLD+2) cycles.
- Requests from non-granted requesters are ignored until IDLE; no preemption.
- Arithmetic:
  - ptr and sel are 2-bit, wrap modulo 4.
  - cnt is CW-bit and never decrements below 0.

Decomposition:
- Shared include next to the 74xx library header, holding:
  - `define` state codes: IDLE=2'd0, SETUP=2'd1, GRANT=2'd2; 2'd3 is illegal and recovers to IDLE with str=1.
  - The STR_OFF=1 constant.
- One combinational sub-module rr_pick4:
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: winner[1:0], any.
  - Reusable by other round-robin users.
- Scheduler FSM and registers stay in mux153_rr_sched.

Test Plan (HOLD=4; mux inputs a=11, b=10, c=01, d=00; real SN74XX153 model in bench):
- Reset then req=0010: gnt=0010 and sel=01 at E0; str=0 at E1; dout=10 with dout_valid=1 for 4 edges starting E2; str=1 and busy=0 after.
- req=1111 held 48 cycles: gnt sequence 0001,0010,0100,1000,0001, period 24; dout cycles 11,10,01,00; str=1 on every edge where sel changes.
- req=0100 dropped after 2 valid samples: str=1 and gnt=0 the following edge; dout_valid=0 on that edge; ptr=3, so next req=1001 grants requester 3 first.
- req pulse 0001 lasting only the IDLE cycle: SETUP aborts; str never 0; dout_valid never 1; back to IDLE in 2 edges.
- rst asserted during GRANT of requester 2: next edge str=1, gnt=0, sel=00, dout_valid=0, ptr=0; with req=0100 still high, grant re-issued per normal latency.
- HOLD=1 build with req=1000: exactly one dout_valid=1 with dout=00 per grant; 3-cycle period (IDLE, SETUP, GRANT).
